snake_ctrl: RTL

Game sequencer for the snake display pipeline, clocked on `pclk` alongside the background, apple and draw stages. It holds the snake body as a shift buffer of grid coordinates and advances the head one grid cell per move tick. It detects wall, self and apple hits, requests a new apple position from the random-coordinate generator over a req/ack handshake, and exposes a registered body read port for the drawing stage.

---
 rtl/snake_pkg.sv | 15 +
 rtl/snake_ctrl_move_tick_gen.sv | 19 +
 rtl/snake_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared FSM states, direction codes, coordinate widths and the
// per-direction step helper used by snake_ctrl.
package snake_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_MOVE, S_CHECK, S_EAT, S_OVER} state_t;
    localparam logic [1:0] DIR_UP = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN = 2'd2;
    localparam logic [1:0] DIR_LEFT = 2'd3;
    localparam int X_W = 7;
    localparam int Y_W = 6;
    // {dx, dy} as 2-bit two's complement deltas; up is y-1.
    function automatic logic [3:0] step(input logic [1:0] dir);
        return dir == DIR_UP ? 4'b0011 : dir == DIR_RIGHT ? 4'b0100 : dir == DIR_DOWN ? 4'b0001 : 4'b1100;
    endfunction
endpackage

// File: rtl/snake_ctrl_move_tick_gen.sv
// move_tick_gen: TICK_DIV cycle counter with enable and sync clear; one-cycle tick.
module move_tick_gen #(
    parameter int TICK_DIV = 4333333
) (
    input  logic pclk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(TICK_DIV - 1);
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr || tick) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/snake_ctrl.sv
// snake_ctrl: snake game sequencer with body shift buffer, hit detection and apple handshake.
// Build option SNAKE_WRAP_EN: wrap at the grid edges instead of ending on a wall hit.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W = 32,
    parameter int GRID_H = 24,
    parameter int MAX_LEN = 16,
    parameter int START_LEN = 3,
    parameter int START_X = 16,
    parameter int START_Y = 12,
    parameter int TICK_DIV = 4333333,
    parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       dir_in,
    input  logic             dir_valid,
    input  logic [6:0]       apple_x,
    input  logic [5:0]       apple_y,
    output logic             apple_req,
    input  logic             apple_ack,
    output logic [6:0]       head_x,
    output logic [5:0]       head_y,
    output logic [LEN_W-1:0] length,
    input  logic [LEN_W-1:0] rd_idx,
    output logic [6:0]       rd_x,
    output logic [5:0]       rd_y,
    output logic             running,
    output logic             game_over
);
    localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    state_t state, next;
    logic [X_W-1:0] seg_x [MAX_LEN];
    logic [Y_W-1:0] seg_y [MAX_LEN];
    logic [1:0] cur_dir, pend_dir;
    logic [LEN_W-1:0] idx;
    logic [3:0] st;
    logic [X_W-1:0] nx, mx;
    logic [Y_W-1:0] ny, my;
    logic tick, die, hit, last, apple_hit;

    move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .pclk(pclk),
        .rst(rst),
        .en(state == S_RUN),
        .clr(start && (state == S_IDLE || state == S_OVER)),
        .tick(tick)
    );

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];
    assign running = state == S_RUN || state == S_MOVE || state == S_CHECK || state == S_EAT;
    assign game_over = state == S_OVER;

    always_comb begin
        st = step(pend_dir);
        nx = seg_x[0] + {{(X_W-2){st[3]}}, st[3:2]};
        ny = seg_y[0] + {{(Y_W-2){st[1]}}, st[1:0]};
`ifdef SNAKE_WRAP_EN
        die = 1'b0;
        mx = nx == X_W'(GRID_W) ? '0 : nx > X_W'(GRID_W) ? X_W'(GRID_W - 1) : nx;
        my = ny == Y_W'(GRID_H) ? '0 : ny > Y_W'(GRID_H) ? Y_W'(GRID_H - 1) : ny;
`else
        // Stepping below zero wraps the unsigned value far above the grid.
        die = nx >= X_W'(GRID_W) || ny >= Y_W'(GRID_H);
        mx = nx;
        my = ny;
`endif
        hit = seg_x[0] == seg_x[idx[IW-1:0]] && seg_y[0] == seg_y[idx[IW-1:0]];
        last = idx >= length - LEN_W'(1);
        apple_hit = seg_x[0] == apple_x && seg_y[0] == apple_y;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = start ? S_RUN : S_IDLE;
            S_RUN:   next = tick ? S_MOVE : S_RUN;
            S_MOVE:  next = die ? S_OVER : S_CHECK;
            S_CHECK: next = (length > LEN_W'(1) && hit) ? S_OVER : last ? (apple_hit ? S_EAT : S_RUN) : S_CHECK;
            S_EAT:   next = (apple_req && apple_ack) ? S_RUN : S_EAT;
            S_OVER:  next = start ? S_RUN : S_OVER;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else state <= next;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= X_W'(START_X - i);
                seg_y[i] <= Y_W'(START_Y);
            end
            cur_dir <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            length <= LEN_W'(START_LEN);
            idx <= '0;
            apple_req <= 1'b0;
            rd_x <= '0;
            rd_y <= '0;
        end else begin
            rd_x <= rd_idx < LEN_W'(MAX_LEN) ? seg_x[rd_idx[IW-1:0]] : '0;
            rd_y <= rd_idx < LEN_W'(MAX_LEN) ? seg_y[rd_idx[IW-1:0]] : '0;
            // Reversal is judged against the last executed move, not the pending one.
            if (dir_valid && state != S_IDLE && state != S_OVER && dir_in != (cur_dir ^ 2'd2))
                pend_dir <= dir_in;
            if (state == S_MOVE) begin
                cur_dir <= pend_dir;
                idx <= LEN_W'(1);
                if (!die) begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0] <= mx;
                    seg_y[0] <= my;
                end
            end
            if (state == S_CHECK) idx <= idx + LEN_W'(1);
            if (state == S_EAT) begin
                if (!apple_req) apple_req <= 1'b1;
                else if (apple_ack) begin
                    apple_req <= 1'b0;
                    length <= length == LEN_W'(MAX_LEN) ? length : length + LEN_W'(1);
                end
            end
            if (state == S_OVER && start) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    seg_x[i] <= X_W'(START_X - i);
                    seg_y[i] <= Y_W'(START_Y);
                end
                cur_dir <= DIR_RIGHT;
                pend_dir <= DIR_RIGHT;
                length <= LEN_W'(START_LEN);
            end
        end
    end
endmodule
